pipelined_array_multiplier: RTL and testbench

PIPELINED_ARRAY_MULTIPLIER -- requirements
Module: pipelined_array_multiplier

---
 rtl/pipelined_array_multiplier.sv | 181 ++++++++++++++++++
 tb/tb_pipelined_array_multiplier.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_array_multiplier.sv
// pipelined_array_multiplier
// Carry-save Baugh-Wooley array multiplier with selectable row registers.
module pipelined_array_multiplier #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-2:0] STAGE_MASK = '1,
  parameter int               TAG_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [2*WIDTH-1:0] Z_final,
  output logic [TAG_W-1:0]   o_tag
);
  localparam int N = WIDTH;

  typedef struct packed {
    logic             v;
    logic             s;
    logic [TAG_W-1:0] tag;
    logic [N-1:0]     sum;
    logic [N-1:0]     cry;
    logic [N-2:0]     zlo;
  } stg_t;

  logic                adv;
  logic                in_v;
  logic                in_s;
  logic [TAG_W-1:0]    in_tag;
  logic [N-1:0]        in_a;
  logic [N-1:0]        in_b;
  logic [N-1:0][N-1:0] pp;
  stg_t                s0;
  stg_t                fin;
  logic [N-1:0]        top;
  logic [N-1:0]        hi;
  logic                rc;
  logic [2*N-1:0]      prod;

  assign adv     = !o_valid || o_ready;
  assign i_ready = adv;

  // Operand capture; the mode bit and tag travel with the operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_v   <= 1'b0;
      in_s   <= 1'b0;
      in_tag <= '0;
      in_a   <= '0;
      in_b   <= '0;
    end else if (adv) begin
      in_v   <= i_valid;
      in_s   <= i_signed;
      in_tag <= i_tag;
      in_a   <= A;
      in_b   <= B;
    end
  end

  // Partial products; mixed-sign terms are inverted in signed mode
  always_comb begin
    pp = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pp[i][j] = (in_a[j] & in_b[i]) ^
                   (in_s & ((i == N-1) != (j == N-1)));
      end
    end
  end

  // Row 0 of the partial products seeds the running sum
  always_comb begin
    s0     = '0;
    s0.v   = in_v;
    s0.s   = in_s;
    s0.tag = in_tag;
    s0.sum = pp[0];
  end

  for (genvar k = 0; k < N-1; k++) begin : g_row
    stg_t                  cur;
    stg_t                  nxt;
    stg_t                  q;
    logic [N-1:k+1][N-1:0] cur_pp;
    logic [N-1:0]          xin;

    if (k == 0) begin : g_first
      assign cur    = s0;
      assign cur_pp = pp[N-1:1];
    end else begin : g_next
      assign cur    = g_row[k-1].q;
      assign cur_pp = g_row[k-1].g_pp.q_pp;
    end

    // Top cell of row 0 also absorbs the signed-mode 2^N constant
    assign xin = {(k == 0) ? cur.s : 1'b0, cur.sum[N-1:1]};

    // One full adder per column folds partial-product row k+1 in
    always_comb begin
      nxt        = cur;
      nxt.zlo[k] = cur.sum[0];
      for (int j = 0; j < N; j++) begin
        nxt.sum[j] = xin[j] ^ cur_pp[k+1][j] ^ cur.cry[j];
        nxt.cry[j] = (xin[j] & cur_pp[k+1][j]) |
                     (xin[j] & cur.cry[j]) |
                     (cur_pp[k+1][j] & cur.cry[j]);
      end
    end

    if (STAGE_MASK[k]) begin : g_ff
      stg_t q_r;
      // Row-sum pipeline register
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_r <= '0;
        end else if (adv) begin
          q_r <= nxt;
        end
      end
      assign q = q_r;
    end else begin : g_comb
      assign q = nxt;
    end

    if (k < N-2) begin : g_pp
      logic [N-1:k+2][N-1:0] q_pp;
      if (STAGE_MASK[k]) begin : g_ff
        logic [N-1:k+2][N-1:0] pp_r;
        // Unconsumed partial products follow their row sums
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pp_r <= '0;
          end else if (adv) begin
            pp_r <= cur_pp[N-1:k+2];
          end
        end
        assign q_pp = pp_r;
      end else begin : g_comb
        assign q_pp = cur_pp[N-1:k+2];
      end
    end
  end

  assign fin = g_row[N-2].q;
  // Top bit carries the signed-mode 2^(2N-1) constant
  assign top = {fin.s, fin.sum[N-1:1]};

  // Final ripple row resolves the upper half of the product
  always_comb begin
    rc = 1'b0;
    hi = '0;
    for (int j = 0; j < N; j++) begin
      hi[j] = top[j] ^ fin.cry[j] ^ rc;
      rc    = (top[j] & fin.cry[j]) |
              (top[j] & rc) |
              (fin.cry[j] & rc);
    end
  end

  assign prod = {hi, fin.sum[0], fin.zlo};

  // Output register; payload is zero whenever the slot is empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      Z_final <= '0;
      o_tag   <= '0;
    end else if (adv) begin
      o_valid <= fin.v;
      Z_final <= fin.v ? prod : '0;
      o_tag   <= fin.v ? fin.tag : '0;
    end
  end

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// tb_pipelined_array_multiplier
// Directed and random checks against an arithmetic model, nine configurations.
module tb_pipelined_array_multiplier;
  localparam int NCFG = 9;
  localparam int MAIN = 4;

  function automatic int cfg_w(input int g);
    return (g < 3) ? 4 : (g < 6) ? 8 : 16;
  endfunction

  function automatic logic [31:0] cfg_mask(input int g);
    logic [31:0] full;
    full = (32'd1 << (cfg_w(g) - 1)) - 32'd1;
    case (g % 3)
      0:       return 32'd0;
      1:       return full;
      default: return full & 32'h5555_5555;
    endcase
  endfunction

  typedef struct {
    logic [31:0] z;
    logic [3:0]  tag;
    int          t;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCFG-1:0] iv;
  logic [NCFG-1:0] ordy;
  logic [NCFG-1:0] ir;
  logic [NCFG-1:0] ov;
  logic            sgn;
  logic [15:0]     a_bus;
  logic [15:0]     b_bus;
  logic [3:0]      tag_in;
  logic [31:0]     z_arr [NCFG];
  logic [3:0]      ot_arr [NCFG];

  int   ntests = 0;
  int   nfail  = 0;
  int   cyc    = 0;
  int   n;
  exp_t q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int           W = cfg_w(g);
    localparam logic [W-2:0] M = (W-1)'(cfg_mask(g));
    logic [2*W-1:0] z;
    pipelined_array_multiplier #(
      .WIDTH(W),
      .STAGE_MASK(M),
      .TAG_W(4)
    ) dut (
      .clk(clk),
      .rst(rst),
      .i_valid(iv[g]),
      .i_ready(ir[g]),
      .i_signed(sgn),
      .A(a_bus[W-1:0]),
      .B(b_bus[W-1:0]),
      .i_tag(tag_in),
      .o_valid(ov[g]),
      .o_ready(ordy[g]),
      .Z_final(z),
      .o_tag(ot_arr[g])
    );
    assign z_arr[g] = 32'(z);
  end

  function automatic logic [31:0] model(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input bit s, input int w);
    longint m;
    longint ax;
    longint bx;
    longint p;
    m  = (longint'(1) << w) - 1;
    ax = longint'(a) & m;
    bx = longint'(b) & m;
    if (s) begin
      if (ax[w-1]) ax = ax - (longint'(1) << w);
      if (bx[w-1]) bx = bx - (longint'(1) << w);
    end
    p = ax * bx;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step(input int idx, input bit v,
                      input logic [15:0] a, input logic [15:0] b,
                      input bit s, input logic [3:0] t,
                      input bit r, input bit cl);
    int lat;
    lat = 2 + $countones(cfg_mask(idx));
    if (ov[idx]) begin
      chk($sformatf("spurious[%0d]", idx), 64'(q.size() != 0), 1);
      if (q.size() != 0) begin
        chk($sformatf("z[%0d]", idx), z_arr[idx], q[0].z);
        chk($sformatf("tag[%0d]", idx), ot_arr[idx], q[0].tag);
      end
    end else begin
      chk($sformatf("idle_z[%0d]", idx), z_arr[idx], 0);
      chk($sformatf("idle_tag[%0d]", idx), ot_arr[idx], 0);
    end
    a_bus     = a;
    b_bus     = b;
    sgn       = s;
    tag_in    = t;
    iv[idx]   = v;
    ordy[idx] = r;
    #1;
    chk($sformatf("i_ready[%0d]", idx), ir[idx], !ov[idx] || r);
    if (v && ir[idx]) begin
      q.push_back('{model(a, b, s, cfg_w(idx)), t, cyc});
    end
    if (ov[idx] && r && q.size() != 0) begin
      if (cl) chk($sformatf("latency[%0d]", idx), cyc - q[0].t, lat);
      void'(q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int idx, input bit cl);
    int k;
    k = 0;
    while (q.size() != 0 && k < 300) begin
      step(idx, 1'b0, 16'd0, 16'd0, 1'b0, 4'd0, 1'b1, cl);
      k++;
    end
    chk($sformatf("drain[%0d]", idx), q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    iv     = '0;
    ordy   = '1;
    sgn    = 1'b0;
    a_bus  = '0;
    b_bus  = '0;
    tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", ov, 0);
    chk("rst_ir", ir, {NCFG{1'b1}});
    chk("rst_z", z_arr[MAIN], 0);
    chk("rst_tag", ot_arr[MAIN], 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 255*255 unsigned, explicit latency and value
    step(MAIN, 1'b1, 16'd255, 16'd255, 1'b0, 4'd3, 1'b1, 1'b1);
    n = 1;
    while (!ov[MAIN] && n < 20) begin
      step(MAIN, 1'b0, 16'd0, 16'd0, 1'b0, 4'd0, 1'b1, 1'b1);
      n++;
    end
    chk("u255_lat", n, 9);
    chk("u255_z", z_arr[MAIN], 32'hFE01);
    chk("u255_tag", ot_arr[MAIN], 3);
    drain(MAIN, 1'b1);

    // signed corners back to back, then same operands unsigned
    step(MAIN, 1'b1, 16'h80, 16'hFF, 1'b1, 4'd1, 1'b1, 1'b1);
    step(MAIN, 1'b1, 16'h80, 16'h80, 1'b1, 4'd2, 1'b1, 1'b1);
    step(MAIN, 1'b1, 16'h80, 16'hFF, 1'b0, 4'd3, 1'b1, 1'b1);
    step(MAIN, 1'b1, 16'h7F, 16'h80, 1'b1, 4'd4, 1'b1, 1'b1);
    drain(MAIN, 1'b1);

    // streaming i*(i+1)
    for (int i = 0; i < 20; i++) begin
      step(MAIN, 1'b1, 16'(i), 16'(i + 1), 1'b0, 4'(i), 1'b1, 1'b1);
    end
    drain(MAIN, 1'b1);

    // backpressure while results are valid
    for (int i = 0; i < 24; i++) begin
      step(MAIN, 1'b1, 16'(i * 3), 16'(i + 7), 1'(i % 2), 4'(i),
           !(i >= 12 && i < 17), 1'b0);
    end
    drain(MAIN, 1'b0);

    // reset mid-stream
    for (int i = 0; i < 11; i++) begin
      step(MAIN, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom % 2),
           4'(i), 1'b1, 1'b0);
    end
    iv = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ov", ov[MAIN], 0);
    chk("midrst_z", z_arr[MAIN], 0);
    chk("midrst_tag", ot_arr[MAIN], 0);
    chk("midrst_ir", ir[MAIN], 1);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(MAIN, 1'b1, 16'd200, 16'd13, 1'b0, 4'd9, 1'b1, 1'b1);
    drain(MAIN, 1'b1);

    // sweep all configurations
    for (int g = 0; g < NCFG; g++) begin
      for (int i = 0; i < 60; i++) begin
        step(g, 1'($urandom % 4 != 0),
             (i % 7 == 0) ? 16'(32'd1 << (cfg_w(g) - 1)) : 16'($urandom),
             (i % 5 == 0) ? 16'hFFFF : 16'($urandom),
             1'($urandom % 2), 4'($urandom),
             1'($urandom % 3 != 0), 1'b0);
      end
      drain(g, 1'b0);
      for (int i = 0; i < 12; i++) begin
        step(g, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom % 2),
             4'($urandom), 1'b1, 1'b1);
      end
      drain(g, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
